// File: rtl/alu_frame_ctrl.sv
// Multi-byte UART framing controller for the combinational ALU: assembles A/B/opcode
// frames, drives the ALU and streams the result back. Define ALU_FRAME_TIMEOUT_EN for the inter-byte timeout.
module alu_frame_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int SIZEDATA       = 16,
  parameter int SIZEOP         = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_parity_err,
  input  logic [SIZEDATA-1:0]   i_alu_result,
  input  logic                  i_tx_done,
  output logic [SIZEDATA-1:0]   o_alu_datoa,
  output logic [SIZEDATA-1:0]   o_alu_datob,
  output logic [SIZEOP-1:0]     o_alu_opcode,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_frame_err,
  output logic [1:0]            o_err_code
);

  localparam int NB = SIZEDATA / DATA_WIDTH;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX_SEND, TX_WAIT} state_t;
  typedef enum logic [1:0] {
    ERR_NONE = 2'b00, ERR_PARITY = 2'b01, ERR_TIMEOUT = 2'b10, ERR_OVERRUN = 2'b11
  } err_t;

  state_t              state, state_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [SIZEDATA-1:0] sh_a, sh_b, result;
  logic                last_byte, timeout_hit;
  logic                err_set, err_clr, load_alu, latch_result;
  err_t                err_next;

  assign last_byte = (cnt == CW'(NB - 1));
  assign o_tx_data = result[cnt*DATA_WIDTH +: DATA_WIDTH];

`ifdef ALU_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          mid_frame;
  logic [TW-1:0] to_cnt;

  // The idle first-byte position of RX_A is the only receive slot that may wait forever.
  assign mid_frame = ((state == RX_A) && (cnt != '0)) || (state == RX_B) || (state == RX_OP);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)                     to_cnt <= '0;
    else if (i_rx_done || !mid_frame) to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
  end

  // Fires in the TIMEOUT_CYCLES-th cycle after the last byte; a byte in that cycle wins.
  assign timeout_hit = mid_frame && !i_rx_done && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= RX_A;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next   = state;
    cnt_next     = cnt;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    err_next     = ERR_NONE;
    load_alu     = 1'b0;
    latch_result = 1'b0;
    o_tx_start   = 1'b0;
    o_busy       = 1'b0;
    case (state)
      RX_A, RX_B, RX_OP: begin
        if (i_rx_done && i_rx_parity_err) begin
          state_next = RX_A;
          cnt_next   = '0;
          err_set    = 1'b1;
          err_next   = ERR_PARITY;
        end else if (i_rx_done) begin
          if ((state == RX_A) && (cnt == '0)) err_clr = 1'b1;
          if (state == RX_OP) begin
            load_alu   = 1'b1;
            state_next = EXEC;
            cnt_next   = '0;
          end else if (last_byte) begin
            state_next = (state == RX_A) ? RX_B : RX_OP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = RX_A;
          cnt_next   = '0;
          err_set    = 1'b1;
          err_next   = ERR_TIMEOUT;
        end
      end
      EXEC: begin
        o_busy       = 1'b1;
        latch_result = 1'b1;
        state_next   = TX_SEND;
      end
      TX_SEND: begin
        o_busy     = 1'b1;
        o_tx_start = 1'b1;
        state_next = TX_WAIT;
      end
      TX_WAIT: begin
        o_busy = 1'b1;
        if (i_tx_done) begin
          cnt_next   = last_byte ? '0 : cnt + 1'b1;
          state_next = last_byte ? RX_A : TX_SEND;
        end
      end
      default: begin
        state_next = RX_A;
        cnt_next   = '0;
      end
    endcase
    // Bytes arriving while the result is in flight are dropped; transmission is unaffected.
    if (o_busy && i_rx_done) begin
      err_set  = 1'b1;
      err_next = ERR_OVERRUN;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      // NOTE: the shadow/result registers are tiny, so they are reset like the rest of the outputs.
      sh_a         <= '0;
      sh_b         <= '0;
      result       <= '0;
      o_alu_datoa  <= '0;
      o_alu_datob  <= '0;
      o_alu_opcode <= '0;
      o_frame_err  <= 1'b0;
      o_err_code   <= 2'b00;
    end else begin
      if (i_rx_done && !i_rx_parity_err) begin
        if (state == RX_A) sh_a[cnt*DATA_WIDTH +: DATA_WIDTH] <= i_rx_data;
        if (state == RX_B) sh_b[cnt*DATA_WIDTH +: DATA_WIDTH] <= i_rx_data;
      end
      // Operands and opcode move together so the ALU never sees a partial frame.
      if (load_alu) begin
        o_alu_datoa  <= sh_a;
        o_alu_datob  <= sh_b;
        o_alu_opcode <= i_rx_data[SIZEOP-1:0];
      end
      if (latch_result) result <= i_alu_result;
      if (err_set) begin
        o_frame_err <= 1'b1;
        o_err_code  <= err_next;
      end else if (err_clr) begin
        o_frame_err <= 1'b0;
        o_err_code  <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Self-checking bench for alu_frame_ctrl: directed scenarios plus randomized frames
// checked against a frame-level reference model (SIZEDATA=16, TIMEOUT_CYCLES=50).
module tb_alu_frame_ctrl;

  localparam int DW = 8;
  localparam int SD = 16;
  localparam int SO = 6;
  localparam int TO = 50;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_parity_err = 1'b0;
  logic          tx_done = 1'b0;
  logic [SD-1:0] alu_result;
  logic [SD-1:0] alu_a, alu_b;
  logic [SO-1:0] alu_op;
  logic [DW-1:0] tx_data;
  logic          tx_start, busy, frame_err;
  logic [1:0]    err_code;

  int checks = 0;
  int failures = 0;

  logic          exp_err = 1'b0;
  logic [1:0]    exp_code = 2'b00;
  logic [SD-1:0] prev_a = '0, prev_b = '0;
  logic [SO-1:0] prev_op = '0;

  alu_frame_ctrl #(
    .DATA_WIDTH(DW), .SIZEDATA(SD), .SIZEOP(SO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clock), .i_reset(reset_n),
    .i_rx_done(rx_done), .i_rx_data(rx_data), .i_rx_parity_err(rx_parity_err),
    .i_alu_result(alu_result), .i_tx_done(tx_done),
    .o_alu_datoa(alu_a), .o_alu_datob(alu_b), .o_alu_opcode(alu_op),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy),
    .o_frame_err(frame_err), .o_err_code(err_code)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   alu_fn = a + b;
      6'h22:   alu_fn = a - b;
      6'h24:   alu_fn = a & b;
      6'h25:   alu_fn = a | b;
      6'h26:   alu_fn = a ^ b;
      6'h27:   alu_fn = ~(a | b);
      6'h02:   alu_fn = a >> b[3:0];
      default: alu_fn = 16'h0000;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic perr);
    rx_data       = d;
    rx_parity_err = perr;
    rx_done       = 1'b1;
    tick();
    rx_done       = 1'b0;
    rx_parity_err = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (alu_a !== 0 || alu_b !== 0 || alu_op !== 0 || tx_data !== 0 || tx_start !== 0 ||
        busy !== 0 || frame_err !== 0 || err_code !== 0) begin
      failures++;
      $display("FAIL %s: got a=%h b=%h op=%h txd=%h start=%b busy=%b err=%b code=%b, expected all 0",
               tag, alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err, err_code);
    end
  endtask

  // Sends one full frame with `gap` idle cycles between A-high and B-low, then
  // services the transmission; optionally injects an overrun byte during the first TX_WAIT.
  task automatic do_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] opb,
                          input int gap, input bit overrun);
    logic [15:0] exp;
    logic [5:0]  op;
    int          w;
    op  = opb[5:0];
    exp = alu_fn(a, b, op);
    send_byte(a[7:0], 1'b0);
    exp_err  = 1'b0;
    exp_code = 2'b00;
    checks++;
    if (frame_err !== 1'b0 || err_code !== 2'b00) begin
      failures++;
      $display("FAIL first_byte_clear: got err=%b code=%b, expected 0/00", frame_err, err_code);
    end
    send_byte(a[15:8], 1'b0);
    repeat (gap) tick();
    send_byte(b[7:0], 1'b0);
    send_byte(b[15:8], 1'b0);
    checks++;
    if (alu_a !== prev_a || alu_b !== prev_b || alu_op !== prev_op || busy !== 1'b0 ||
        frame_err !== 1'b0) begin
      failures++;
      $display("FAIL partial_hold: got a=%h b=%h op=%h busy=%b err=%b, expected a=%h b=%h op=%h busy=0 err=0",
               alu_a, alu_b, alu_op, busy, frame_err, prev_a, prev_b, prev_op);
    end
    send_byte(opb, 1'b0);
    checks++;
    if (alu_a !== a || alu_b !== b || alu_op !== op || busy !== 1'b1 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL exec_operands: got a=%h b=%h op=%h busy=%b start=%b, expected a=%h b=%h op=%h busy=1 start=0",
               alu_a, alu_b, alu_op, busy, tx_start, a, b, op);
    end
    prev_a  = a;
    prev_b  = b;
    prev_op = op;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (tx_start !== 1'b1 || tx_data !== exp[8*k +: 8]) begin
        failures++;
        $display("FAIL tx_byte%0d: got start=%b data=%h, expected start=1 data=%h",
                 k, tx_start, tx_data, exp[8*k +: 8]);
      end
      w = $urandom_range(1, 3);
      tick();
      checks++;
      if (tx_start !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL tx_wait%0d: got start=%b busy=%b, expected start=0 busy=1", k, tx_start, busy);
      end
      if (overrun && k == 0) begin
        rx_data = 8'hAA;
        rx_done = 1'b1;
        tick();
        rx_done  = 1'b0;
        exp_err  = 1'b1;
        exp_code = 2'b11;
        checks++;
        if (frame_err !== 1'b1 || err_code !== 2'b11) begin
          failures++;
          $display("FAIL overrun_flag: got err=%b code=%b, expected 1/11", frame_err, err_code);
        end
      end
      repeat (w - 1) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || frame_err !== exp_err || err_code !== exp_code) begin
      failures++;
      $display("FAIL frame_end: got busy=%b start=%b err=%b code=%b, expected busy=0 start=0 err=%b code=%b",
               busy, tx_start, frame_err, err_code, exp_err, exp_code);
    end
  endtask

  task automatic test_reset();
    #3;
    check_all_zero("reset_state");
    tick();
    reset_n = 1'b1;
    tick();
    check_all_zero("after_release");
  endtask

  task automatic test_nominal();
    do_frame(16'h1234, 16'h0101, 8'h20, 0, 1'b0);
  endtask

  task automatic test_parity();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    repeat (4) tick();
    checks++;
    if (frame_err !== 1'b1 || err_code !== 2'b01 || alu_a !== prev_a || alu_b !== prev_b) begin
      failures++;
      $display("FAIL parity_flag: got err=%b code=%b a=%h b=%h, expected 1/01 a=%h b=%h",
               frame_err, err_code, alu_a, alu_b, prev_a, prev_b);
    end
    exp_err  = 1'b1;
    exp_code = 2'b01;
    do_frame(16'h0005, 16'h0003, 8'h22, 0, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef ALU_FRAME_TIMEOUT_EN
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    repeat (TO - 1) tick();
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got err=%b at %0d cycles, expected 0", frame_err, TO - 1);
    end
    tick();
    checks++;
    if (frame_err !== 1'b1 || err_code !== 2'b10 || alu_a !== prev_a) begin
      failures++;
      $display("FAIL timeout_flag: got err=%b code=%b a=%h, expected 1/10 a=%h",
               frame_err, err_code, alu_a, prev_a);
    end
    do_frame(16'h4321, 16'h1111, 8'h22, TO - 1, 1'b0);
`else
    do_frame(16'h4321, 16'h1111, 8'h22, 4 * TO, 1'b0);
`endif
  endtask

  task automatic test_overrun();
    do_frame(16'h00F0, 16'h000F, 8'h25, 0, 1'b1);
    do_frame(16'h1111, 16'h2222, 8'h26, 0, 1'b0);
  endtask

  task automatic test_reset_mid_tx();
    int bad_starts;
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0);
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hBF) begin
      failures++;
      $display("FAIL pre_reset_byte1: got start=%b data=%h, expected 1/bf", tx_start, tx_data);
    end
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    tick();
    reset_n = 1'b1;
    prev_a = '0; prev_b = '0; prev_op = '0;
    exp_err = 1'b0; exp_code = 2'b00;
    bad_starts = 0;
    for (int i = 0; i < 20; i++) begin
      tx_done = 1'($urandom_range(0, 1));
      tick();
      if (tx_start !== 1'b0 || busy !== 1'b0) bad_starts++;
    end
    tx_done = 1'b0;
    checks++;
    if (bad_starts != 0) begin
      failures++;
      $display("FAIL post_reset_idle: got %0d cycles with start/busy, expected 0", bad_starts);
    end
    do_frame(16'hBEEF, 16'h0102, 8'h20, 0, 1'b0);
  endtask

  task automatic test_spurious_tx_done();
    int bad;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tx_done = 1'b1;
      tick();
      if (tx_start !== 1'b0 || busy !== 1'b0) bad++;
    end
    tx_done = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL spurious_tx_done: got %0d cycles with start/busy, expected 0", bad);
    end
    do_frame(16'hA5A5, 16'h0F0F, 8'h24, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02};
    logic [7:0] opb;
    for (int i = 0; i < 12; i++) begin
      opb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 6)]};
      do_frame(16'($urandom), 16'($urandom), opb, $urandom_range(0, 5),
               ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_parity();
    test_timeout();
    test_overrun();
    test_reset_mid_tx();
    test_spurious_tx_done();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_frame_ctrl.md
# alu_frame_ctrl

Multi-byte framing controller between the UART byte interface and the combinational ALU, and the next generation of the single-byte interface block. It assembles operands of SIZEDATA bits from several received bytes and checks each byte for parity errors and overrun. An optional inter-byte timeout is also checked. It then drives the ALU and returns the SIZEDATA-bit result as a paced multi-byte transmission, handshaking on the UART transmitter's done pulse.

## Interface
- DATA_WIDTH, 8, UART byte width
- SIZEDATA, 16, operand/result width; must be an integer multiple of DATA_WIDTH; NB = SIZEDATA/DATA_WIDTH
- SIZEOP, 6, opcode width (≤ DATA_WIDTH)
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clocks (only with ALU_FRAME_TIMEOUT_EN)

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_done  in  1  one-cycle strobe: received byte valid
- i_rx_data  in  DATA_WIDTH  received byte, valid with i_rx_done
- i_rx_parity_err  in  1  parity error for the current byte, valid with i_rx_done
- i_alu_result  in  SIZEDATA  ALU result (combinational from o_alu_*)
- i_tx_done  in  1  one-cycle strobe: transmitter finished the current byte
- o_alu_datoa  out  SIZEDATA  operand A (registered)
- o_alu_datob  out  SIZEDATA  operand B (registered)
- o_alu_opcode  out  SIZEOP  opcode (registered)
- o_tx_data  out  DATA_WIDTH  byte to transmit
- o_tx_start  out  1  one-cycle strobe: start transmitting o_tx_data
- o_busy  out  1  high from EXEC until the last result byte is done
- o_frame_err  out  1  sticky error flag
- o_err_code  out  2  00 none, 01 parity, 10 timeout, 11 overrun

## Operation
- Frame: NB bytes of A (LSB first), then NB bytes of B (LSB first), then 1 opcode byte; the low SIZEOP bits are used.
- States: RX_A → RX_B → RX_OP → EXEC → TX_SEND → TX_WAIT → (TX_SEND | RX_A).
- Byte counter: 0..NB-1 in RX_A/RX_B, 0..NB-1 in TX_*; wraps to 0 on each state change.
- Bytes are assembled into shadow registers. o_alu_datoa, o_alu_datob and o_alu_opcode are all updated together when the opcode byte is accepted, so the ALU never sees a partial frame.
- EXEC: i_alu_result is latched into a result register.
- TX_SEND: o_tx_data = result byte k; o_tx_start is high for one cycle; go to TX_WAIT.
- TX_WAIT: on i_tx_done, either advance k and return to TX_SEND, or, after byte NB-1, go to RX_A.
- Parity error on any accepted byte: discard the partial frame, go to RX_A, set o_frame_err with code 01. o_alu_* keep their previous values.
- Overrun: i_rx_done in EXEC/TX_SEND/TX_WAIT drops the byte and sets o_frame_err with code 11. Transmission continues unaffected.
- Error clear: o_frame_err/o_err_code are cleared when the first byte of a new frame is accepted without a parity error. A later error overwrites the code.
- i_tx_done outside TX_WAIT is ignored.

## Timing
- Reset (i_reset low, async): state RX_A, counters 0, and every output 0 (o_alu_*, o_tx_data, o_tx_start, o_busy, o_frame_err, o_err_code).
- Reset mid-frame or mid-transmission aborts immediately; no tx_start is issued after release until a new full frame arrives.
- Opcode byte strobe in cycle N:
  - o_alu_* valid from N+1; state EXEC in N+1; o_busy high from N+1.
  - Result latched at the end of N+1.
  - o_tx_start with byte 0 in N+2.
- Next o_tx_start comes 1 cycle after each i_tx_done.
- o_busy falls in the cycle after the last i_tx_done; RX_A accepts bytes from that cycle.
- Timeout: TIMEOUT_CYCLES clocks without i_rx_done after any accepted byte mid-frame (not in RX_A with count 0) → discard and go to RX_A. Error is flagged in cycle last_byte + TIMEOUT_CYCLES.
- If i_rx_done coincides with the timeout cycle, the byte wins and the counter restarts.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.

## Configuration
- ALU_FRAME_TIMEOUT_EN defined: the inter-byte timeout counter is present as described.
- Undefined: no counter is synthesised, a partial frame waits indefinitely, code 10 is never produced, and TIMEOUT_CYCLES is ignored.

## Test plan
- Nominal, SIZEDATA=16: bytes 0x34,0x12,0x01,0x01,0x20 (ADD) → o_alu_datoa=0x1234, o_alu_datob=0x0101; o_tx_start twice with 0x35 then 0x13, each paced by i_tx_done; o_busy returns to 0.
- Parity: error on the 3rd byte, then a clean frame 0x05,0x00,0x03,0x00,0x22 (SUB) → o_frame_err=1 with code 01 until the first clean byte; result bytes 0x02,0x00.
- Timeout (macro on, TIMEOUT_CYCLES=50): 2 bytes then idle → code 10 exactly 50 cycles after the 2nd strobe. A byte arriving on cycle 50 instead → no error.
- Overrun: i_rx_done 0xAA during TX_WAIT → code 11; both result bytes are still sent correctly; 0xAA does not appear in the next frame.
- Reset: assert i_reset low between result bytes 0 and 1 → all outputs 0 and no further o_tx_start; a following full frame is processed normally.
- Spurious i_tx_done in RX_A → no state change and no o_tx_start.
